// File: rtl/wishbone_slave_adapter_gen_if.sv
// Wishbone classic bus bundle between a shared-bus master port and the
// peripheral slave adapter. Signal names keep the slave-side _i/_o
// orientation so they match the adapter's view of the bus.
interface wishbone_slave_adapter_gen_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
) ();

  logic [AW-1:0]   wb_addr_i;
  logic [DW-1:0]   wb_data_i;
  logic [DW-1:0]   wb_data_o;
  logic            wb_we_i;
  logic            wb_stb_i;
  logic            wb_cyc_i;
  logic [DW/8-1:0] wb_sel_i;
  logic            wb_ack_o;
  logic            wb_err_o;

  // Bus master side: issues requests, receives data and terminations.
  modport master (
    output wb_addr_i, wb_data_i, wb_we_i, wb_stb_i, wb_cyc_i, wb_sel_i,
    input  wb_data_o, wb_ack_o, wb_err_o
  );

  // Adapter side: accepts requests, returns data and terminations.
  modport slave (
    input  wb_addr_i, wb_data_i, wb_we_i, wb_stb_i, wb_cyc_i, wb_sel_i,
    output wb_data_o, wb_ack_o, wb_err_o
  );

endinterface

// File: rtl/wishbone_slave_adapter_gen.sv
// Generic Wishbone classic slave adapter for one register-mapped peripheral.
// Decodes a base/span window, answers out-of-window accesses with a bus
// error, latches the request fields, issues single-cycle read/write strobes
// to the peripheral, optionally waits a fixed number of cycles before
// sampling read data, and terminates each accepted request with one ack.
module wishbone_slave_adapter_gen #(
  parameter int unsigned     DW          = 32,
  parameter int unsigned     AW          = 32,
  parameter logic [AW-1:0]   BASE_ADDR   = {AW{1'b0}},
  parameter int unsigned     SPAN_LOG2   = 4,
  parameter int unsigned     WAIT_STATES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst,
  wishbone_slave_adapter_gen_if.slave wb,
  output logic [SPAN_LOG2-1:0]  per_addr_o,
  output logic [DW-1:0]         per_wdata_o,
  output logic [DW/8-1:0]       per_sel_o,
  output logic                  per_we_o,
  output logic                  per_re_o,
  input  logic [DW-1:0]         per_rdata_i
);

  // Wait-state count as stored in the down-counter (0..15).
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACCESS   = 3'd1,
    ST_WAIT     = 3'd2,
    ST_ACK      = 3'd3,
    ST_ERR      = 3'd4,
    ST_COOLDOWN = 3'd5
  } state_t;

  state_t                 state_r;
  logic [3:0]             cnt_r;
  logic                   we_r;
  logic [SPAN_LOG2-1:0]   addr_r;
  logic [DW-1:0]          wdata_r;
  logic [DW/8-1:0]        sel_r;
  logic [DW-1:0]          rdata_r;
  logic                   ack_r;
  logic                   err_r;
  logic                   per_we_r;
  logic                   per_re_r;

  logic                   req_s;
  logic                   hit_s;
  logic                   sel_any_s;

  // Request qualification and window decode on the upper address bits.
  always_comb begin
    req_s     = wb.wb_stb_i & wb.wb_cyc_i;
    hit_s     = (wb.wb_addr_i[AW-1:SPAN_LOG2] == BASE_ADDR[AW-1:SPAN_LOG2]);
    sel_any_s = |wb.wb_sel_i;
  end

  // Transaction FSM; every output is a register updated on the transition
  // into the state that shows it, so strobes and terminations are clean
  // one-cycle pulses.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      we_r     <= 1'b0;
      addr_r   <= {SPAN_LOG2{1'b0}};
      wdata_r  <= {DW{1'b0}};
      sel_r    <= {(DW/8){1'b0}};
      rdata_r  <= {DW{1'b0}};
      ack_r    <= 1'b0;
      err_r    <= 1'b0;
      per_we_r <= 1'b0;
      per_re_r <= 1'b0;
    end else begin
      // Pulses default low; the states below raise them for one cycle.
      ack_r    <= 1'b0;
      err_r    <= 1'b0;
      per_we_r <= 1'b0;
      per_re_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_s) begin
            if (hit_s) begin
              // Accept: latch the request and strobe the peripheral while
              // in ACCESS. A write with no byte lanes is acked but never
              // reaches the peripheral.
              addr_r   <= wb.wb_addr_i[SPAN_LOG2-1:0];
              wdata_r  <= wb.wb_data_i;
              sel_r    <= wb.wb_sel_i;
              we_r     <= wb.wb_we_i;
              per_we_r <= wb.wb_we_i & sel_any_s;
              per_re_r <= ~wb.wb_we_i;
              state_r  <= ST_ACCESS;
            end else begin
              err_r   <= 1'b1;
              state_r <= ST_ERR;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_ACCESS: begin
          if (!wb.wb_cyc_i) begin
            // Master abandoned the cycle; the strobe already went out.
            state_r <= ST_IDLE;
          end else if (WAIT_CNT == 4'd0) begin
            if (!we_r) begin
              rdata_r <= per_rdata_i;
            end else begin
              rdata_r <= rdata_r;
            end
            ack_r   <= 1'b1;
            state_r <= ST_ACK;
          end else begin
            cnt_r   <= WAIT_CNT;
            state_r <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (!wb.wb_cyc_i) begin
            state_r <= ST_IDLE;
          end else if (cnt_r <= 4'd1) begin
            // Last wait cycle: peripheral data is valid now.
            if (!we_r) begin
              rdata_r <= per_rdata_i;
            end else begin
              rdata_r <= rdata_r;
            end
            cnt_r   <= 4'd0;
            ack_r   <= 1'b1;
            state_r <= ST_ACK;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end

        ST_ACK: begin
          state_r <= ST_COOLDOWN;
        end

        ST_ERR: begin
          state_r <= ST_COOLDOWN;
        end

        ST_COOLDOWN: begin
          // One idle cycle so a held strobe cannot retrigger immediately.
          state_r <= ST_IDLE;
        end

        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign wb.wb_data_o = rdata_r;
  assign wb.wb_ack_o  = ack_r;
  assign wb.wb_err_o  = err_r;
  assign per_addr_o   = addr_r;
  assign per_wdata_o  = wdata_r;
  assign per_sel_o    = sel_r;
  assign per_we_o     = per_we_r;
  assign per_re_o     = per_re_r;

endmodule

// File: tb/tb_wishbone_slave_adapter_gen.sv
// Bench for the Wishbone slave adapter: two instances (0 and 3 wait states)
// share one stimulus stream; each transaction is observed for a fixed
// window and per-cycle events are compared with hand-computed values.
module tb_wishbone_slave_adapter_gen;

  localparam int NCYC = 16;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        stb;
  logic        cyc;
  logic [3:0]  sel;
  logic [31:0] rdata;

  logic [3:0]  per_addr0, per_addr3;
  logic [31:0] per_wdata0, per_wdata3;
  logic [3:0]  per_sel0, per_sel3;
  logic        per_we0, per_we3, per_re0, per_re3;

  wishbone_slave_adapter_gen_if #(.DW(32), .AW(32)) bus0 ();
  wishbone_slave_adapter_gen_if #(.DW(32), .AW(32)) bus3 ();

  assign bus0.wb_addr_i = addr;
  assign bus0.wb_data_i = wdata;
  assign bus0.wb_we_i   = we;
  assign bus0.wb_stb_i  = stb;
  assign bus0.wb_cyc_i  = cyc;
  assign bus0.wb_sel_i  = sel;
  assign bus3.wb_addr_i = addr;
  assign bus3.wb_data_i = wdata;
  assign bus3.wb_we_i   = we;
  assign bus3.wb_stb_i  = stb;
  assign bus3.wb_cyc_i  = cyc;
  assign bus3.wb_sel_i  = sel;

  wishbone_slave_adapter_gen #(
    .DW(32), .AW(32), .BASE_ADDR(32'h4000_0000), .SPAN_LOG2(4), .WAIT_STATES(0)
  ) dut0 (
    .clk_i(clk), .rst(rst), .wb(bus0),
    .per_addr_o(per_addr0), .per_wdata_o(per_wdata0), .per_sel_o(per_sel0),
    .per_we_o(per_we0), .per_re_o(per_re0), .per_rdata_i(rdata)
  );

  wishbone_slave_adapter_gen #(
    .DW(32), .AW(32), .BASE_ADDR(32'h4000_0000), .SPAN_LOG2(4), .WAIT_STATES(3)
  ) dut3 (
    .clk_i(clk), .rst(rst), .wb(bus3),
    .per_addr_o(per_addr3), .per_wdata_o(per_wdata3), .per_sel_o(per_sel3),
    .per_we_o(per_we3), .per_re_o(per_re3), .per_rdata_i(rdata)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Per-DUT observations of the latest transaction window (index 0: W=0, 1: W=3).
  int          ack_cnt[2], ack_first[2], ack_second[2];
  int          err_cnt[2], err_first[2];
  int          re_cnt[2], we_cnt[2], strobe_first[2];
  int          viol[2];
  logic        zero_ok[2];
  logic        prev_re[2], prev_we[2];
  logic        s_ack[2], s_err[2], s_re[2], s_we[2];
  logic [31:0] o_data[2], o_wdata[2];
  logic [3:0]  o_paddr[2], o_sel[2];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] rdata;
    logic        hit;
    logic        we_pulse;
    logic [31:0] exp_data;
    logic [3:0]  exp_paddr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_sel;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sample_outputs();
    s_ack[0] = bus0.wb_ack_o;  s_ack[1] = bus3.wb_ack_o;
    s_err[0] = bus0.wb_err_o;  s_err[1] = bus3.wb_err_o;
    s_re[0]  = per_re0;        s_re[1]  = per_re3;
    s_we[0]  = per_we0;        s_we[1]  = per_we3;
    o_data[0]  = bus0.wb_data_o; o_data[1]  = bus3.wb_data_o;
    o_paddr[0] = per_addr0;      o_paddr[1] = per_addr3;
    o_wdata[0] = per_wdata0;     o_wdata[1] = per_wdata3;
    o_sel[0]   = per_sel0;       o_sel[1]   = per_sel3;
  endtask

  function automatic logic all_zero(input int d);
    return (o_data[d] == 32'd0) && !s_ack[d] && !s_err[d] && (o_paddr[d] == 4'd0) &&
           (o_wdata[d] == 32'd0) && (o_sel[d] == 4'd0) && !s_re[d] && !s_we[d];
  endfunction

  // One request accepted at edge T, then NCYC observed cycles T+1..T+NCYC.
  // stb is held for stb_len edges; cyc drops / rdata changes / rst pulses
  // at the start of cycle T+k for the given k (0 = never).
  task automatic run(input logic [31:0] a, input logic [31:0] wd, input logic w,
                     input logic [3:0] s, input logic [31:0] rd, input int stb_len,
                     input int cyc_drop_k, input int chg_k, input logic [31:0] chg_val,
                     input int rst_k);
    for (int d = 0; d < 2; d++) begin
      ack_cnt[d] = 0; ack_first[d] = -1; ack_second[d] = -1;
      err_cnt[d] = 0; err_first[d] = -1;
      re_cnt[d] = 0; we_cnt[d] = 0; strobe_first[d] = -1;
      viol[d] = 0; zero_ok[d] = 1'b0; prev_re[d] = 1'b0; prev_we[d] = 1'b0;
    end
    @(posedge clk); #1;
    addr = a; wdata = wd; we = w; sel = s; rdata = rd; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= NCYC; k++) begin
      if (k == stb_len) stb = 1'b0;
      if (k == cyc_drop_k) cyc = 1'b0;
      if (k == chg_k) rdata = chg_val;
      if (k == rst_k) rst = 1'b1;
      if (k == rst_k + 1) rst = 1'b0;
      @(negedge clk);
      sample_outputs();
      for (int d = 0; d < 2; d++) begin
        if (s_ack[d]) begin
          ack_cnt[d]++;
          if (ack_first[d] < 0) ack_first[d] = k;
          else if (ack_second[d] < 0) ack_second[d] = k;
        end
        if (s_err[d]) begin
          err_cnt[d]++;
          if (err_first[d] < 0) err_first[d] = k;
        end
        if (s_re[d]) re_cnt[d]++;
        if (s_we[d]) we_cnt[d]++;
        if ((s_re[d] || s_we[d]) && strobe_first[d] < 0) strobe_first[d] = k;
        if (s_ack[d] && s_err[d]) viol[d]++;
        if ((s_re[d] && prev_re[d]) || (s_we[d] && prev_we[d])) viol[d]++;
        prev_re[d] = s_re[d];
        prev_we[d] = s_we[d];
        if (rst_k > 0 && k == rst_k + 1) zero_ok[d] = all_zero(d);
      end
      @(posedge clk); #1;
    end
    stb = 1'b0; cyc = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr = 32'd0; wdata = 32'd0; we = 1'b0; stb = 1'b0; cyc = 1'b0;
    sel = 4'd0; rdata = 32'd0;

    vecs[0] = '{32'h4000_0004, 32'h0000_0000, 1'b0, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'h4, 32'h0000_0000, 4'hF};
    vecs[1] = '{32'h4000_0008, 32'hA5A5_0001, 1'b1, 4'h3, 32'h0000_0000, 1'b1, 1'b1, 32'hDEAD_BEEF, 4'h8, 32'hA5A5_0001, 4'h3};
    vecs[2] = '{32'h5000_0000, 32'h2222_2222, 1'b0, 4'hF, 32'h1111_1111, 1'b0, 1'b0, 32'hDEAD_BEEF, 4'h8, 32'hA5A5_0001, 4'h3};
    vecs[3] = '{32'h4000_000C, 32'h0BAD_F00D, 1'b1, 4'h0, 32'h7777_7777, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'hC, 32'h0BAD_F00D, 4'h0};
    vecs[4] = '{32'h4000_000F, 32'h1357_9BDF, 1'b0, 4'hF, 32'hCAFE_F00D, 1'b1, 1'b0, 32'hCAFE_F00D, 4'hF, 32'h1357_9BDF, 4'hF};
    vecs[5] = '{32'h4000_0010, 32'h0000_0000, 1'b0, 4'hF, 32'h5555_5555, 1'b0, 1'b0, 32'hCAFE_F00D, 4'hF, 32'h1357_9BDF, 4'hF};
    vecs[6] = '{32'h3FFF_FFFF, 32'h0000_0000, 1'b1, 4'hF, 32'h0000_0000, 1'b0, 1'b0, 32'hCAFE_F00D, 4'hF, 32'h1357_9BDF, 4'hF};
    vecs[7] = '{32'h4000_0000, 32'hFFFF_FFFF, 1'b1, 4'h8, 32'h9999_9999, 1'b1, 1'b1, 32'hCAFE_F00D, 4'h0, 32'hFFFF_FFFF, 4'h8};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    sample_outputs();
    check("reset_zero_w0", 32'(all_zero(0)), 32'd1);
    check("reset_zero_w3", 32'(all_zero(1)), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven single transactions.
    for (int i = 0; i < 8; i++) begin
      run(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].sel, vecs[i].rdata, 1, 0, 0, 32'd0, 0);
      for (int d = 0; d < 2; d++) begin
        string t;
        int    ack_t;
        t = $sformatf("v%0d_w%0d", i, (d == 0) ? 0 : 3);
        ack_t = vecs[i].hit ? ((d == 0) ? 2 : 5) : -1;
        check({t, "_ack_cnt"}, 32'(ack_cnt[d]), 32'(vecs[i].hit));
        check({t, "_ack_cycle"}, 32'(ack_first[d]), 32'(ack_t));
        check({t, "_err_cnt"}, 32'(err_cnt[d]), 32'(!vecs[i].hit));
        check({t, "_err_cycle"}, 32'(err_first[d]), vecs[i].hit ? 32'hFFFF_FFFF : 32'd1);
        check({t, "_re_cnt"}, 32'(re_cnt[d]), 32'(vecs[i].hit && !vecs[i].we));
        check({t, "_we_cnt"}, 32'(we_cnt[d]), 32'(vecs[i].we_pulse));
        check({t, "_strobe_cycle"}, 32'(strobe_first[d]),
              (vecs[i].hit && (vecs[i].we_pulse || !vecs[i].we)) ? 32'd1 : 32'hFFFF_FFFF);
        check({t, "_rdata"}, o_data[d], vecs[i].exp_data);
        check({t, "_paddr"}, 32'(o_paddr[d]), 32'(vecs[i].exp_paddr));
        check({t, "_wdata"}, o_wdata[d], vecs[i].exp_wdata);
        check({t, "_sel"}, 32'(o_sel[d]), 32'(vecs[i].exp_sel));
        check({t, "_viol"}, 32'(viol[d]), 32'd0);
      end
    end

    // Read data changing during the wait states: W=3 samples it late.
    run(32'h4000_0004, 32'd0, 1'b0, 4'hF, 32'h0000_0000, 1, 0, 3, 32'h1234_5678, 0);
    check("late_w0_ack_cycle", 32'(ack_first[0]), 32'd2);
    check("late_w3_ack_cycle", 32'(ack_first[1]), 32'd5);
    check("late_w0_rdata", o_data[0], 32'h0000_0000);
    check("late_w3_rdata", o_data[1], 32'h1234_5678);

    // Write with stb held six edges: W=3 sees one transaction, W=0 re-accepts at T+4.
    run(32'h4000_0008, 32'hA5A5_0001, 1'b1, 4'h3, 32'h0, 6, 0, 0, 32'd0, 0);
    check("hold_w3_we_cnt", 32'(we_cnt[1]), 32'd1);
    check("hold_w3_we_cycle", 32'(strobe_first[1]), 32'd1);
    check("hold_w3_ack_cnt", 32'(ack_cnt[1]), 32'd1);
    check("hold_w3_wdata", o_wdata[1], 32'hA5A5_0001);
    check("hold_w3_sel", 32'(o_sel[1]), 32'd3);
    check("hold_w3_rdata", o_data[1], 32'h1234_5678);
    check("hold_w0_we_cnt", 32'(we_cnt[0]), 32'd2);
    check("hold_w0_ack_second", 32'(ack_second[0]), 32'd6);
    check("hold_w0_rdata", o_data[0], 32'h0000_0000);
    check("hold_viol", 32'(viol[0] + viol[1]), 32'd0);

    // Abort: cyc dropped at T+2 while W=3 is waiting.
    run(32'h4000_0004, 32'd0, 1'b0, 4'hF, 32'hABCD_0000, 1, 2, 0, 32'd0, 0);
    check("abort_w3_ack_cnt", 32'(ack_cnt[1]), 32'd0);
    check("abort_w3_err_cnt", 32'(err_cnt[1]), 32'd0);
    check("abort_w3_re_cnt", 32'(re_cnt[1]), 32'd1);
    check("abort_w3_rdata", o_data[1], 32'h1234_5678);
    check("abort_w0_ack_cycle", 32'(ack_first[0]), 32'd2);
    check("abort_w0_rdata", o_data[0], 32'hABCD_0000);

    // Back-to-back reads with stb/cyc held: acks 4+W cycles apart.
    run(32'h4000_0004, 32'd0, 1'b0, 4'hF, 32'h0F0F_0F0F, 12, 0, 0, 32'd0, 0);
    check("b2b_w0_ack_cnt", 32'(ack_cnt[0]), 32'd3);
    check("b2b_w0_re_cnt", 32'(re_cnt[0]), 32'd3);
    check("b2b_w0_spacing", 32'(ack_second[0] - ack_first[0]), 32'd4);
    check("b2b_w3_ack_cnt", 32'(ack_cnt[1]), 32'd2);
    check("b2b_w3_re_cnt", 32'(re_cnt[1]), 32'd2);
    check("b2b_w3_spacing", 32'(ack_second[1] - ack_first[1]), 32'd7);
    check("b2b_w3_rdata", o_data[1], 32'h0F0F_0F0F);
    check("b2b_viol", 32'(viol[0] + viol[1]), 32'd0);

    // Reset asserted at T+3 while W=3 is in its wait states.
    run(32'h4000_0004, 32'd0, 1'b0, 4'hF, 32'h0000_0001, 1, 0, 0, 32'd0, 3);
    check("rst_w3_zero_next", 32'(zero_ok[1]), 32'd1);
    check("rst_w0_zero_next", 32'(zero_ok[0]), 32'd1);
    check("rst_w3_ack_cnt", 32'(ack_cnt[1]), 32'd0);
    check("rst_w0_ack_cnt", 32'(ack_cnt[0]), 32'd1);
    check("rst_w0_rdata", o_data[0], 32'h0000_0000);
    check("rst_w3_paddr", 32'(o_paddr[1]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
